// File: rtl/mjpg_pkg.sv
// Shared types and constants for the MJPG entropy request scheduler and encoder top.
package mjpg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN_Y  = 3'd1,
    ST_RUN_CB = 3'd2,
    ST_RUN_CR = 3'd3,
    ST_GUARD  = 3'd4
  } sched_state_e;

  localparam int WIN_Y_DEF  = 29;
  localparam int WIN_C_DEF  = 7;
  localparam int GUARD_DEF  = 8;
  localparam int MCU_PERIOD = WIN_Y_DEF + 2 * WIN_C_DEF + GUARD_DEF;

  // ereq bit positions, also used by the encoder top
  localparam int EREQ_Y  = 0;
  localparam int EREQ_CB = 1;
  localparam int EREQ_CR = 2;

  function automatic logic [2:0] ereq_onehot(input int pos);
    return 3'b001 << pos;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/mjpg_slot_timer.sv
// Window counter: counts cycles within a slot and strobes on the slot's last cycle.
module mjpg_slot_timer
  import mjpg_pkg::*;
#(
  parameter int TW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic [TW-1:0] i_len,
  output logic          o_last
);

  localparam logic [TW-1:0] W_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] W_ZERO = {TW{1'b0}};

  logic [TW-1:0] r_wcnt;

  // Restart on every slot entry, otherwise count up.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wcnt <= W_ZERO;
    end else if (i_clr) begin
      r_wcnt <= W_ZERO;
    end else begin
      r_wcnt <= r_wcnt + W_ONE;
    end
  end

  assign o_last = (r_wcnt == (i_len - W_ONE));

endmodule

// File: rtl/mjpg_ereq_scheduler.sv
// Time-sliced Y/Cb/Cr entropy request scheduler for one MCU row with abort/overrun handling.
// Optional evalid collision checker enabled by defining MJPG_SCHED_COLLISION_CHECK_EN.
module mjpg_ereq_scheduler
  import mjpg_pkg::*;
#(
  parameter int MCU_W = 8,
  parameter int WIN_Y = WIN_Y_DEF,
  parameter int WIN_C = WIN_C_DEF,
  parameter int GUARD = GUARD_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [MCU_W-1:0] i_h_mcu,
  input  logic [3:0]       i_evalid,
  output logic [2:0]       o_ereq,
  output logic [MCU_W-1:0] o_x_mcu_y,
  output logic [MCU_W-1:0] o_x_mcu_cb,
  output logic [MCU_W-1:0] o_x_mcu_cr,
  output logic             o_busy,
  output logic             o_row_done,
  output logic             o_err_overrun,
  output logic             o_err_collision
);

  localparam int TW = $clog2(max3(WIN_Y, WIN_C, GUARD) + 1);
  localparam logic [MCU_W-1:0] X_ZERO = {MCU_W{1'b0}};
  localparam logic [MCU_W-1:0] X_ONE  = {{(MCU_W-1){1'b0}}, 1'b1};

  sched_state_e     r_state;
  logic [MCU_W-1:0] r_h_mcu;
  logic [MCU_W-1:0] r_x_y, r_x_cb, r_x_cr;
  logic [2:0]       r_ereq;
  logic             r_busy, r_row_done, r_err_overrun;
  logic [TW-1:0]    w_len;
  logic             w_last, w_clr;

  // Slot length for the current state.
  always_comb begin
    w_len = TW'(1);
    case (r_state)
      ST_RUN_Y:  w_len = TW'(WIN_Y);
      ST_RUN_CB: w_len = TW'(WIN_C);
      ST_RUN_CR: w_len = TW'(WIN_C);
      ST_GUARD:  w_len = TW'(GUARD);
      default:   w_len = TW'(1);
    endcase
  end

  assign w_clr = w_last | i_abort | (r_state == ST_IDLE);

  mjpg_slot_timer #(.TW(TW)) u_slot_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_clr),
    .i_len  (w_len),
    .o_last (w_last)
  );

  // Row FSM with registered request, index and status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_h_mcu       <= X_ZERO;
      r_x_y         <= X_ZERO;
      r_x_cb        <= X_ZERO;
      r_x_cr        <= X_ZERO;
      r_ereq        <= 3'b000;
      r_busy        <= 1'b0;
      r_row_done    <= 1'b0;
      r_err_overrun <= 1'b0;
    end else if (i_abort) begin
      r_state    <= ST_IDLE;
      r_x_y      <= X_ZERO;
      r_x_cb     <= X_ZERO;
      r_x_cr     <= X_ZERO;
      r_ereq     <= 3'b000;
      r_busy     <= 1'b0;
      r_row_done <= 1'b0;
    end else begin
      r_row_done <= 1'b0;
      if (i_start && r_busy) begin
        r_err_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_h_mcu != X_ZERO) begin
              r_state <= ST_RUN_Y;
              r_h_mcu <= i_h_mcu;
              r_busy  <= 1'b1;
              r_ereq  <= ereq_onehot(EREQ_Y);
            end else begin
              r_row_done <= 1'b1;
            end
          end
        end
        ST_RUN_Y: begin
          if (w_last) begin
            r_state <= ST_RUN_CB;
            r_ereq  <= ereq_onehot(EREQ_CB);
            r_x_y   <= r_x_y + X_ONE;
          end
        end
        ST_RUN_CB: begin
          if (w_last) begin
            r_state <= ST_RUN_CR;
            r_ereq  <= ereq_onehot(EREQ_CR);
            r_x_cb  <= r_x_cb + X_ONE;
          end
        end
        ST_RUN_CR: begin
          if (w_last) begin
            r_state <= ST_GUARD;
            r_ereq  <= 3'b000;
            r_x_cr  <= r_x_cr + X_ONE;
          end
        end
        ST_GUARD: begin
          if (w_last) begin
            if (r_x_cr == r_h_mcu) begin
              r_state    <= ST_IDLE;
              r_busy     <= 1'b0;
              r_row_done <= 1'b1;
              r_x_y      <= X_ZERO;
              r_x_cb     <= X_ZERO;
              r_x_cr     <= X_ZERO;
            end else begin
              r_state <= ST_RUN_Y;
              r_ereq  <= ereq_onehot(EREQ_Y);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ereq  <= 3'b000;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ereq        = r_ereq;
  assign o_x_mcu_y     = r_x_y;
  assign o_x_mcu_cb    = r_x_cb;
  assign o_x_mcu_cr    = r_x_cr;
  assign o_busy        = r_busy;
  assign o_row_done    = r_row_done;
  assign o_err_overrun = r_err_overrun;

`ifdef MJPG_SCHED_COLLISION_CHECK_EN
  logic [3:0] r_evalid;
  logic       r_err_collision;

  // Register evalid once, then flag any cycle where several sources drove the bitstream.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_evalid        <= 4'b0000;
      r_err_collision <= 1'b0;
    end else begin
      r_evalid <= i_evalid;
      if (popcount4(r_evalid) > 3'd1) begin
        r_err_collision <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // Report the offending evalid value in simulation.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (popcount4(r_evalid) > 3'd1)) begin
      $display("mjpg_ereq_scheduler: evalid collision 0x%0h", r_evalid);
    end
  end
`endif

  assign o_err_collision = r_err_collision;
`else
  logic w_unused_evalid;
  assign w_unused_evalid = ^i_evalid;
  assign o_err_collision = 1'b0;
`endif

endmodule

// File: tb/tb_mjpg_ereq_scheduler.sv
// Directed self-checking bench for mjpg_ereq_scheduler at default parameters.
module tb_mjpg_ereq_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] h_mcu;
  logic [3:0] evalid;
  logic [2:0] ereq;
  logic [7:0] x_y, x_cb, x_cr;
  logic       busy, row_done, err_overrun, err_collision;

  int errors = 0;
  int checks = 0;

  mjpg_ereq_scheduler dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_abort         (abort),
    .i_h_mcu         (h_mcu),
    .i_evalid        (evalid),
    .o_ereq          (ereq),
    .o_x_mcu_y       (x_y),
    .o_x_mcu_cb      (x_cb),
    .o_x_mcu_cr      (x_cr),
    .o_busy          (busy),
    .o_row_done      (row_done),
    .o_err_overrun   (err_overrun),
    .o_err_collision (err_collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench in cycle T+1 after the accepting edge T.
  task automatic pulse_start(input logic [7:0] h);
    start = 1'b1;
    h_mcu = h;
    tick();
    start = 1'b0;
  endtask

  // Request pattern inside one 51-cycle MCU period, offset 1..51.
  function automatic logic [2:0] exp_ereq(input int off);
    if (off <= 29)      return 3'b001;
    else if (off <= 36) return 3'b010;
    else if (off <= 43) return 3'b100;
    else                return 3'b000;
  endfunction

  initial begin
    int bad;
    int rd;
    int cnt;
    int mx;
    bit done;

    rst = 1'b1; start = 1'b0; abort = 1'b0; h_mcu = 8'd0; evalid = 4'b0000;
    tick(); tick();
    check("rst_ereq", ereq, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_idx", {x_y, x_cb, x_cr}, 24'd0);
    check("rst_flags", {row_done, err_overrun, err_collision}, 3'b000);
    rst = 1'b0;
    tick();

    // h_mcu=2 full row timing
    pulse_start(8'd2);
    for (int k = 1; k <= 104; k++) begin
      check($sformatf("t1_ereq_c%0d", k), ereq, (k <= 102) ? exp_ereq(((k - 1) % 51) + 1) : 3'b000);
      check($sformatf("t1_busy_c%0d", k), busy, (k <= 102) ? 1'b1 : 1'b0);
      check($sformatf("t1_done_c%0d", k), row_done, (k == 103) ? 1'b1 : 1'b0);
      tick();
    end

    // h_mcu=3 index sampling
    pulse_start(8'd3);
    for (int k = 1; k <= 155; k++) begin
      for (int m = 0; m < 3; m++) begin
        if (k == 51 * m + 15) check($sformatf("t2_xy_m%0d", m), x_y, m);
        if (k == 51 * m + 33) begin
          check($sformatf("t2_xcb_m%0d", m), x_cb, m);
          check($sformatf("t2_xy_in_cb_m%0d", m), x_y, m + 1);
        end
        if (k == 51 * m + 40) begin
          check($sformatf("t2_xcr_m%0d", m), x_cr, m);
          check($sformatf("t2_xcb_in_cr_m%0d", m), x_cb, m + 1);
        end
      end
      if (k == 154) begin
        check("t2_done", row_done, 1'b1);
        check("t2_idx_clear", {x_y, x_cb, x_cr}, 24'd0);
      end
      if (k == 155) check("t2_done_1cyc", row_done, 1'b0);
      tick();
    end

    // abort during RUN_CB of MCU 1
    pulse_start(8'd2);
    for (int k = 1; k < 84; k++) tick();
    check("t3_pre_ereq", ereq, 3'b010);
    check("t3_pre_xcb", x_cb, 8'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_ereq", ereq, 3'b000);
    check("t3_busy", busy, 1'b0);
    check("t3_idx", {x_y, x_cb, x_cr}, 24'd0);
    rd = 0; bad = 0;
    for (int k = 0; k < 120; k++) begin
      if (row_done) rd++;
      if (ereq != 3'b000) bad++;
      tick();
    end
    check("t3_no_row_done", rd, 0);
    check("t3_no_ereq", bad, 0);

    // start+abort together while idle
    start = 1'b1; abort = 1'b1; h_mcu = 8'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (ereq != 3'b000 || busy) bad++;
      tick();
    end
    check("t4_abort_wins", bad, 0);

    // overrun: second start while busy
    pulse_start(8'd2);
    for (int k = 1; k < 10; k++) tick();
    check("t4_ovr_before", err_overrun, 1'b0);
    start = 1'b1; h_mcu = 8'd5;
    tick();
    start = 1'b0;
    check("t4_ovr_set", err_overrun, 1'b1);
    for (int k = 11; k < 102; k++) tick();
    check("t4_busy_c102", busy, 1'b1);
    tick();
    check("t4_done_c103", row_done, 1'b1);
    check("t4_busy_c103", busy, 1'b0);
    check("t4_ovr_sticky", err_overrun, 1'b1);

    // reset mid-row
    pulse_start(8'd3);
    for (int k = 1; k < 40; k++) tick();
    rst = 1'b1;
    #1;
    check("t5_rst_ereq", ereq, 3'b000);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_idx", {x_y, x_cb, x_cr}, 24'd0);
    check("t5_rst_ovr", err_overrun, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("t5_idle_after", busy, 1'b0);

    // h_mcu=0
    pulse_start(8'd0);
    check("t6_h0_done", row_done, 1'b1);
    check("t6_h0_busy", busy, 1'b0);
    check("t6_h0_ereq", ereq, 3'b000);
    tick();
    check("t6_h0_done_1cyc", row_done, 1'b0);
    check("t6_h0_ereq2", ereq, 3'b000);

    // h_mcu=255 full row
    pulse_start(8'd255);
    cnt = 0; mx = 0; bad = 0; done = 1'b0;
    for (int k = 0; k < 13100 && !done; k++) begin
      if (busy) cnt++;
      if (x_cr > mx) mx = x_cr;
      if ((ereq & (ereq - 3'b001)) != 3'b000) bad++;
      if (row_done) done = 1'b1;
      tick();
    end
    check("t7_row_done_seen", done, 1'b1);
    check("t7_busy_cycles", cnt, 13005);
    check("t7_xcr_max", mx, 255);
    check("t7_onehot", bad, 0);

    // evalid collision
    evalid = 4'b0011;
    tick();
    evalid = 4'b0000;
    check("t8_coll_c1", err_collision, 1'b0);
    tick();
`ifdef MJPG_SCHED_COLLISION_CHECK_EN
    check("t8_coll_c2", err_collision, 1'b1);
`else
    check("t8_coll_c2", err_collision, 1'b0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
